// File: rtl/ysyx_23060096_divider_pkg.sv
// Shared definitions for the RV32M divide unit: div_op encodings, FSM state
// encodings and small op-decode helpers.
// Imported by ysyx_23060096_divider; no ports.
package ysyx_23060096_divider_pkg;

  // div_op encodings (match funct3[1:0] of DIV/DIVU/REM/REMU)
  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  // Divider FSM state encodings
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CALC  = 2'd1;
  localparam logic [1:0] ST_FIXUP = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == DIV_OP_DIV) || (op == DIV_OP_REM);
  endfunction

  function automatic logic op_is_rem(input logic [1:0] op);
    return (op == DIV_OP_REM) || (op == DIV_OP_REMU);
  endfunction

endpackage

// File: rtl/ysyx_23060096_adder.sv
// Combinational add/subtract unit; op=1 computes a - b as a + ~b + 1.
// Ports: a, b (operands), op (0 add / 1 sub), result, carry (carry out; for a
// subtract, 1 means a >= b unsigned), zero (result == 0), overflow (signed).
module ysyx_23060096_adder #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         op,
  output logic [W-1:0] result,
  output logic         carry,
  output logic         zero,
  output logic         overflow
);

  logic [W-1:0] b_eff;

  assign b_eff = op ? ~b : b;
  assign {carry, result} = {1'b0, a} + {1'b0, b_eff} + {{W{1'b0}}, op};
  assign zero = (result == '0);
  assign overflow = (a[W-1] == b_eff[W-1]) && (result[W-1] != a[W-1]);

endmodule

// File: rtl/ysyx_23060096_divider.sv
// Iterative RV32M DIV/DIVU/REM/REMU unit, restoring division, one quotient bit per cycle.
// Latency: result valid 34 cycles after accept (32 CALC + FIXUP); divide-by-zero and
// signed overflow finish in 1 cycle. Backpressure: in_ready only in IDLE; result held
// in DONE until out_ready; flush aborts any in-flight op.
// Ports: clk, rst_n (async active-low), in_valid/in_ready/div_op/src1/src2 (request),
// flush (abort), out_valid/out_ready/result (response).
module ysyx_23060096_divider
  import ysyx_23060096_divider_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      div_op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  localparam logic [4:0]      CNT_LAST = 5'd31;
  localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]      state;
  logic [1:0]      op_q;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] dvsr_q;
  logic            neg_quo;
  logic            neg_rem;
  logic [4:0]      counter;
  logic [XLEN-1:0] result_q;

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign result    = result_q;

  // Request decode
  logic            accept;
  logic            req_signed;
  logic            src1_neg;
  logic            src2_neg;
  logic [XLEN-1:0] src1_abs;
  logic [XLEN-1:0] src2_abs;
  logic            div_by_zero;
  logic            sgn_ovf;
  logic [XLEN-1:0] fast_result;

  assign accept      = in_valid & in_ready & ~flush;
  assign req_signed  = op_is_signed(div_op);
  assign src1_neg    = req_signed & src1[XLEN-1];
  assign src2_neg    = req_signed & src2[XLEN-1];
  assign src1_abs    = src1_neg ? (~src1 + 1'b1) : src1;
  assign src2_abs    = src2_neg ? (~src2 + 1'b1) : src2;
  assign div_by_zero = (src2 == '0);
  assign sgn_ovf     = req_signed & (src1 == INT_MIN) & (src2 == '1);

  // Divide by zero returns the raw dividend as remainder, not its magnitude.
  always_comb begin
    fast_result = '0;
    if (div_by_zero) begin
      fast_result = op_is_rem(div_op) ? src1 : '1;
    end else begin
      fast_result = op_is_rem(div_op) ? '0 : INT_MIN;
    end
  end

  // Trial subtract of the divisor from the shifted partial remainder
  logic [XLEN-1:0] partial;
  logic [XLEN-1:0] add_result;
  logic            add_carry;
  logic            add_zero;
  logic            add_overflow;
  logic            take;

  assign partial = {rem_q[XLEN-2:0], quo_q[XLEN-1]};

  ysyx_23060096_adder #(.W(XLEN)) u_adder (
    .a        (partial),
    .b        (dvsr_q),
    .op       (1'b1),
    .result   (add_result),
    .carry    (add_carry),
    .zero     (add_zero),
    .overflow (add_overflow)
  );

  logic unused_adder_flags;
  assign unused_adder_flags = add_zero ^ add_overflow;

  // rem_q[XLEN-1] is the bit shifted out of the partial: the true partial is then
  // at least 2^XLEN, above any divisor, and the wrapped difference is exact.
  assign take = rem_q[XLEN-1] | add_carry;

  logic [XLEN-1:0] fixup_result;
  always_comb begin
    fixup_result = '0;
    if (op_is_rem(op_q)) begin
      fixup_result = neg_rem ? (~rem_q + 1'b1) : rem_q;
    end else begin
      fixup_result = neg_quo ? (~quo_q + 1'b1) : quo_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      op_q     <= DIV_OP_DIV;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      neg_quo  <= 1'b0;
      neg_rem  <= 1'b0;
      counter  <= '0;
      result_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_q    <= div_op;
            quo_q   <= src1_abs;
            dvsr_q  <= src2_abs;
            rem_q   <= '0;
            counter <= '0;
            neg_quo <= src1_neg ^ src2_neg;
            neg_rem <= src1_neg;
            if (div_by_zero | sgn_ovf) begin
              result_q <= fast_result;
              state    <= ST_DONE;
            end else begin
              state <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          if (flush) begin
            state <= ST_IDLE;
          end else begin
            rem_q   <= take ? add_result : partial;
            quo_q   <= {quo_q[XLEN-2:0], take};
            counter <= counter + 5'd1;
            if (counter == CNT_LAST) begin
              state <= ST_FIXUP;
            end
          end
        end
        ST_FIXUP: begin
          if (flush) begin
            state <= ST_IDLE;
          end else begin
            result_q <= fixup_result;
            state    <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (flush | out_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060096_divider.sv
module tb_ysyx_23060096_divider;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  div_op;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;

  int checks;
  int errors;

  ysyx_23060096_divider #(.XLEN(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .div_op    (div_op),
    .src1      (src1),
    .src2      (src2),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Independent reference: RISC-V semantics via the simulator's own arithmetic.
  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int sa;
    int sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return op[1] ? 32'd0 : 32'h8000_0000;
    case (op)
      2'b00:   return 32'(sa / sb);
      2'b01:   return a / b;
      2'b10:   return 32'(sa % sb);
      default: return a % b;
    endcase
  endfunction

  // Issue one op, measure latency (accept edge counts as 1), optionally stall, then retire.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int stall, output logic [31:0] res, output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    div_op   = op;
    src1     = a;
    src2     = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (!out_valid) begin
      errors++;
      $display("FAIL timeout: out_valid=%0b after %0d cycles, required 1", out_valid, lat);
    end
    res = result;
    repeat (stall) begin
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] res;
    int          lat;
    int          seen;
    logic [1:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;

    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    div_op    = 2'b00;
    src1      = 32'd0;
    src2      = 32'd0;
    flush     = 1'b0;
    out_ready = 1'b0;

    vecs[0]  = '{2'b01, 32'd100,        32'd7,          32'd14,         34};
    vecs[1]  = '{2'b11, 32'd100,        32'd7,          32'd2,          34};
    vecs[2]  = '{2'b00, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  34};
    vecs[3]  = '{2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  34};
    vecs[4]  = '{2'b00, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  34};
    vecs[5]  = '{2'b10, 32'd7,          32'hFFFF_FFFE,  32'd1,          34};
    vecs[6]  = '{2'b01, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  34};
    vecs[7]  = '{2'b11, 32'hFFFF_FFFF,  32'h8000_0000,  32'h7FFF_FFFF,  34};
    vecs[8]  = '{2'b01, 32'hFFFF_FFFF,  32'hFFFF_FFFE,  32'd1,          34};
    vecs[9]  = '{2'b00, 32'd5,          32'd0,          32'hFFFF_FFFF,  1};
    vecs[10] = '{2'b10, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB,  1};
    vecs[11] = '{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1};
    vecs[12] = '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1};
    vecs[13] = '{2'b01, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          34};
    vecs[14] = '{2'b00, 32'd0,          32'd5,          32'd0,          34};
    vecs[15] = '{2'b11, 32'd0,          32'd0,          32'd0,          1};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors
    for (int i = 0; i < 16; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, 0, res, lat);
      check($sformatf("vec%0d_result", i), res, vecs[i].exp);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
    end

    // Consumer stall: result and handshake held for 10 cycles
    div_op = 2'b01; src1 = 32'd1000; src2 = 32'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    for (int i = 0; i < 10; i++) begin
      check("stall_result", result, 32'd333);
      check("stall_out_valid", {31'd0, out_valid}, 32'd1);
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("stall_retire_in_ready", {31'd0, in_ready}, 32'd1);

    // Flush during CALC cycle 10
    div_op = 2'b01; src1 = 32'd50; src2 = 32'd5; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
    end
    check("flush_pre_in_ready", {31'd0, in_ready}, 32'd0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_in_ready", {31'd0, in_ready}, 32'd1);
    check("flush_out_valid", {31'd0, out_valid}, 32'd0);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("flush_no_result", 32'(seen), 32'd0);

    // Flush in IDLE blocks an accept (a divide-by-zero would otherwise finish at once)
    div_op = 2'b00; src1 = 32'd9; src2 = 32'd0; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    check("idle_flush_out_valid", {31'd0, out_valid}, 32'd0);
    check("idle_flush_in_ready", {31'd0, in_ready}, 32'd1);

    // Asynchronous reset mid-CALC
    div_op = 2'b01; src1 = 32'd77; src2 = 32'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    check("arst_in_ready", {31'd0, in_ready}, 32'd1);
    check("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check("arst_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("arst_no_result", 32'(seen), 32'd0);

    // Random mixed ops with random consumer stalls
    for (int i = 0; i < 200; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 16));
        3: rb = rb >> $urandom_range(0, 31);
        default: ;
      endcase
      run_op(rop, ra, rb, int'($urandom_range(0, 3)), res, lat);
      check($sformatf("rand%0d op%0d 0x%08h/0x%08h", i, rop, ra, rb), res, ref_div(rop, ra, rb));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule
